data_mem_responder: RTL and testbench

Data-memory responder for the MEM stage of the RV64 pipeline. It accepts one load or store request from the MEM stage, holds the pipeline with a stall while a configurable wait-state counter runs, then commits the store or returns the sign/zero-extended load data. The load data drives the `ReadData` input of the MEM/WB pipeline register. Single-ported, 64-bit-word internal array; RV64I load/store widths only.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/load_store_align.sv | 51 +++++
 rtl/data_mem_responder.sv | 115 +++++++++++
 tb/tb_data_mem_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data memory responder: access-type codes,
// FSM state type and the access-size decode.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam int NUM_LANES = 8;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    size_bytes = 4'd1;
      2'd1:    size_bytes = 4'd2;
      2'd2:    size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: byte enables, store lane shift, load extract with
// sign/zero extension, and misalignment / illegal-encoding detection.
module load_store_align
  import mem_pkg::*;
(
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [2:0]  byte_off,
  input  logic [63:0] wdata,
  input  logic [63:0] rword,
  output logic [7:0]  byte_en,
  output logic [63:0] wdata_lane,
  output logic [63:0] rdata_ext,
  output logic        misalign
);

  logic [3:0]  nbytes;
  logic        illegal;
  logic        off_bad;
  logic [7:0]  be_base;
  logic [63:0] lane;

  always_comb begin
    nbytes  = size_bytes(funct3[1:0]);
    illegal = mem_write ? funct3[2] : (funct3 == 3'b111);
    case (funct3[1:0])
      2'd0:    off_bad = 1'b0;
      2'd1:    off_bad = byte_off[0];
      2'd2:    off_bad = |byte_off[1:0];
      default: off_bad = |byte_off;
    endcase
    misalign = illegal | off_bad;

    be_base    = 8'((9'd1 << nbytes) - 9'd1);
    byte_en    = misalign ? 8'd0 : (be_base << byte_off);
    wdata_lane = wdata << {byte_off, 3'b000};

    lane = rword >> {byte_off, 3'b000};
    case (funct3)
      F3_B:    rdata_ext = {{56{lane[7]}},  lane[7:0]};
      F3_H:    rdata_ext = {{48{lane[15]}}, lane[15:0]};
      F3_W:    rdata_ext = {{32{lane[31]}}, lane[31:0]};
      F3_D:    rdata_ext = lane;
      F3_BU:   rdata_ext = {56'd0, lane[7:0]};
      F3_HU:   rdata_ext = {48'd0, lane[15:0]};
      F3_WU:   rdata_ext = {32'd0, lane[31:0]};
      default: rdata_ext = 64'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory: accepts one load/store, stalls for WAIT_CYCLES wait
// states, then commits the store or registers the extended load data.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [63:0] AddrM,
  input  logic [63:0] WriteDataM,
  output logic [63:0] ReadData,
  output logic        MemBusyM,
  output logic        MemDoneM,
  output logic        MisalignM
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic              commit;

  logic [63:0]       mem_array [DEPTH_WORDS];
  logic [IDX_W-1:0]  idx;
  logic [63:0]       rword;
  logic [7:0]        byte_en;
  logic [63:0]       wdata_lane;
  logic [63:0]       rdata_ext;
  logic              misalign;

  // Upper address bits are dropped, so accesses wrap modulo the array size.
  assign idx   = AddrM[3 +: IDX_W];
  assign rword = mem_array[idx];

  load_store_align u_align (
    .mem_write  (MemWriteM),
    .funct3     (Funct3M),
    .byte_off   (AddrM[2:0]),
    .wdata      (WriteDataM),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (MemReqM) begin
        if (WAIT_CYCLES == 0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
        end
      end
      WAIT: if (cnt_q == '0) begin
        state_d = RESP;
        commit  = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rdata_d = rdata_q;
    mis_d   = 1'b0;
    if (commit) begin
      mis_d = misalign;
      if (misalign)        rdata_d = 64'd0;
      else if (!MemWriteM) rdata_d = rdata_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= 64'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // Array is not reset; a store is suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && commit && MemWriteM) begin
      for (int b = 0; b < NUM_LANES; b++)
        if (byte_en[b]) mem_array[idx][LANE_W*b +: LANE_W] <= wdata_lane[LANE_W*b +: LANE_W];
    end
  end

  assign ReadData  = rdata_q;
  assign MisalignM = mis_q;
  assign MemDoneM  = (state_q == RESP);
  assign MemBusyM  = MemReqM & (state_q != RESP);

endmodule

// File: tb/tb_data_mem_responder.sv
// Three responders (1, 0 and 3 wait states) driven by directed and random
// accesses and compared against a byte-level memory model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req  [3];
  logic        wr   [3];
  logic [2:0]  f3s  [3];
  logic [63:0] ad   [3];
  logic [63:0] wdat [3];
  logic [63:0] rdata[3];
  logic        busy [3];
  logic        done [3];
  logic        mis  [3];

  int wc[3] = '{1, 0, 3};
  int nassert = 0;
  int nfail   = 0;
  int cyc     = 0;

  logic [7:0]  mb [3][8192];
  logic [63:0] rd_exp[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .MemReqM(req[0]), .MemWriteM(wr[0]), .Funct3M(f3s[0]),
    .AddrM(ad[0]), .WriteDataM(wdat[0]), .ReadData(rdata[0]), .MemBusyM(busy[0]),
    .MemDoneM(done[0]), .MisalignM(mis[0]));
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .MemReqM(req[1]), .MemWriteM(wr[1]), .Funct3M(f3s[1]),
    .AddrM(ad[1]), .WriteDataM(wdat[1]), .ReadData(rdata[1]), .MemBusyM(busy[1]),
    .MemDoneM(done[1]), .MisalignM(mis[1]));
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .MemReqM(req[2]), .MemWriteM(wr[2]), .Funct3M(f3s[2]),
    .AddrM(ad[2]), .WriteDataM(wdat[2]), .ReadData(rdata[2]), .MemBusyM(busy[2]),
    .MemDoneM(done[2]), .MisalignM(mis[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit is_mis(input bit w, input logic [2:0] f, input logic [63:0] a);
    bit illegal = w ? f[2] : (f == 3'b111);
    return illegal || ((int'(a[2:0]) % nbytes(f)) != 0);
  endfunction

  function automatic logic [63:0] mdl_load(input int k, input logic [2:0] f, input logic [63:0] a);
    int n = nbytes(f);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mb[k][int'(a[12:0]) + i];
    if (!f[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic mdl_store(input int k, input logic [2:0] f, input logic [63:0] a, input logic [63:0] wd);
    for (int i = 0; i < nbytes(f); i++) mb[k][int'(a[12:0]) + i] = wd[8*i +: 8];
  endtask

  // One complete access on instance k; returns at the negedge inside RESP.
  task automatic acc(input int k, input bit w, input logic [2:0] f, input logic [63:0] a,
                     input logic [63:0] wd);
    int n = 0;
    int busy_n = 1;
    bit m = is_mis(w, f, a);
    @(negedge clk);
    chk("done_low_in_idle", {63'd0, done[k]}, 64'd0);
    req[k] = 1'b1; wr[k] = w; f3s[k] = f; ad[k] = a; wdat[k] = wd;
    #1;
    chk("busy_on_accept", {63'd0, busy[k]}, 64'd1);
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done[k]) break;
      busy_n += int'(busy[k]);
      chk("mis_low_in_wait", {63'd0, mis[k]}, 64'd0);
    end
    chk("latency", 64'(n), 64'(wc[k] + 1));
    chk("busy_cycles", 64'(busy_n), 64'(wc[k] + 1));
    chk("busy_low_in_resp", {63'd0, busy[k]}, 64'd0);
    chk("misalign", {63'd0, mis[k]}, {63'd0, m});
    if (m)       rd_exp[k] = 64'd0;
    else if (w)  mdl_store(k, f, a, wd);
    else         rd_exp[k] = mdl_load(k, f, a);
    chk("read_data", rdata[k], rd_exp[k]);
    req[k] = 1'b0;
  endtask

  initial begin
    int c0;
    logic [2:0]  f;
    logic [63:0] a;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; f3s[k] = 3'd0; ad[k] = 64'd0; wdat[k] = 64'd0;
      rd_exp[k] = 64'd0;
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdata", rdata[k], 64'd0);
      chk("rst_done", {63'd0, done[k]}, 64'd0);
      chk("rst_mis", {63'd0, mis[k]}, 64'd0);
      chk("rst_busy", {63'd0, busy[k]}, 64'd0);
    end
    req[0] = 1'b1;
    #1 chk("rst_busy_follows_req", {63'd0, busy[0]}, 64'd1);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Give every instance known contents in words 0..31.
    for (int k = 0; k < 3; k++)
      for (int wd = 0; wd < 32; wd++)
        acc(k, 1'b1, 3'b011, 64'(wd * 8), {$urandom, $urandom});

    // Directed sequence on the 1-wait-state instance.
    acc(0, 1, 3'b011, 64'h40, 64'h1122334455667788);
    acc(0, 0, 3'b011, 64'h40, 64'd0);
    chk("sd_ld_value", rdata[0], 64'h1122334455667788);
    acc(0, 1, 3'b000, 64'h43, 64'h80);
    acc(0, 0, 3'b000, 64'h43, 64'd0);
    chk("lb_sign", rdata[0], 64'hFFFFFFFFFFFFFF80);
    acc(0, 0, 3'b100, 64'h43, 64'd0);
    chk("lbu_zero", rdata[0], 64'h0000000000000080);
    acc(0, 0, 3'b011, 64'h40, 64'd0);
    chk("byte3_only", rdata[0], 64'h1122334480667788);
    acc(0, 0, 3'b010, 64'h42, 64'd0);
    chk("lw_mis_data", rdata[0], 64'd0);
    acc(0, 1, 3'b001, 64'h41, 64'hBEEF);
    acc(0, 0, 3'b011, 64'h40, 64'd0);
    chk("sh_mis_nowrite", rdata[0], 64'h1122334480667788);
    acc(0, 1, 3'b011, 64'h2000, 64'hAAAA);
    acc(0, 0, 3'b011, 64'h0, 64'd0);
    chk("wrap", rdata[0], 64'hAAAA);

    // Zero-wait back-to-back loads: four accesses in eight cycles.
    c0 = cyc;
    for (int i = 0; i < 4; i++) acc(1, 0, 3'b011, 64'(i * 8), 64'd0);
    chk("b2b_cycles", 64'(cyc - c0), 64'd8);

    // Reset during the second wait state of a store on the 3-wait instance.
    acc(2, 0, 3'b011, 64'h80, 64'd0);
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b1; f3s[2] = 3'b011; ad[2] = 64'h80; wdat[2] = 64'hDEAD;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_rdata", rdata[2], 64'd0);
    chk("midwait_rst_done", {63'd0, done[2]}, 64'd0);
    chk("midwait_rst_mis", {63'd0, mis[2]}, 64'd0);
    chk("midwait_rst_busy", {63'd0, busy[2]}, 64'd1);
    req[2] = 1'b0;
    #1 chk("midwait_rst_busy_drop", {63'd0, busy[2]}, 64'd0);
    for (int k = 0; k < 3; k++) rd_exp[k] = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    acc(2, 0, 3'b011, 64'h80, 64'd0);

    // Random mix, including illegal encodings and high-address aliases.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 25; i++) begin
        f = 3'($urandom_range(0, 7));
        a = 64'($urandom_range(0, 255)) | ({32'($urandom), 32'($urandom)} << 13);
        if ($urandom_range(0, 1) == 1) a[2:0] = a[2:0] & ~3'(nbytes(f) - 1);
        acc(k, 1'($urandom_range(0, 1)), f, a, {$urandom, $urandom});
      end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
